// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter. The in-order pipe writeback and a
// long-latency multi-cycle unit (mcu) share one write port. A pending
// scoreboard tracks registers that still owe an mcu result, feeds the hazard
// busy flags and holds off WAW-unsafe pipe writes. The mcu is given priority
// after STARVE_LIMIT consecutive blocked cycles.
module rf_write_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned NREG         = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pipe_valid,
  input  logic [$clog2(NREG)-1:0]  pipe_rd,
  input  logic [XLEN-1:0]          pipe_data,
  output logic                     pipe_ready,
  input  logic                     mcu_valid,
  input  logic [$clog2(NREG)-1:0]  mcu_rd,
  input  logic [XLEN-1:0]          mcu_data,
  output logic                     mcu_ready,
  input  logic                     claim_valid,
  input  logic [$clog2(NREG)-1:0]  claim_rd,
  input  logic [$clog2(NREG)-1:0]  rs1,
  input  logic [$clog2(NREG)-1:0]  rs2,
  output logic                     rs1_busy,
  output logic                     rs2_busy,
  output logic                     claim_conflict,
  output logic                     write_enable,
  output logic [$clog2(NREG)-1:0]  rd,
  output logic [XLEN-1:0]          rd_din
);

  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);

  logic [NREG-1:0] pending_q, pending_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            conflict_d;
  logic            mcu_wins, pipe_eligible;
  logic            pipe_acc, mcu_acc, claim_set;
  logic            we_d;
  logic [AW-1:0]   rd_d;
  logic [XLEN-1:0] din_d;

  // Arbitration: pipe has fixed priority unless the mcu has starved long enough.
  always_comb begin
    mcu_wins      = (starve_q == StarveMax);
    pipe_eligible = pipe_valid && !pending_q[pipe_rd];
    pipe_ready    = pipe_eligible && !(mcu_valid && mcu_wins);
    mcu_ready     = mcu_valid && (!pipe_eligible || mcu_wins);
    pipe_acc      = pipe_ready;
    mcu_acc       = mcu_ready;
    rs1_busy      = pending_q[rs1];
    rs2_busy      = pending_q[rs2];
  end

  // Next state for scoreboard, starvation counter and write stage.
  always_comb begin
    claim_set = claim_valid && (claim_rd != '0);

    // Clear first so a same-cycle claim to the same register survives.
    pending_d = pending_q;
    if (mcu_acc) pending_d[mcu_rd] = 1'b0;
    if (claim_set) pending_d[claim_rd] = 1'b1;

    conflict_d = claim_conflict ||
                 (claim_set && pending_q[claim_rd] && !(mcu_acc && (mcu_rd == claim_rd)));

    starve_d = starve_q;
    if (!mcu_valid || mcu_acc) begin
      starve_d = '0;
    end else if (starve_q != StarveMax) begin
      starve_d = starve_q + 1'b1;
    end

    // rd/rd_din hold when idle; only write_enable matters to the register file.
    we_d  = 1'b0;
    rd_d  = rd;
    din_d = rd_din;
    if (mcu_acc) begin
      we_d  = (mcu_rd != '0);
      rd_d  = mcu_rd;
      din_d = mcu_data;
    end else if (pipe_acc) begin
      we_d  = (pipe_rd != '0);
      rd_d  = pipe_rd;
      din_d = pipe_data;
    end
  end

  // State update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_q      <= '0;
      starve_q       <= '0;
      claim_conflict <= 1'b0;
      write_enable   <= 1'b0;
      rd             <= '0;
      rd_din         <= '0;
    end else begin
      pending_q      <= pending_d;
      starve_q       <= starve_d;
      claim_conflict <= conflict_d;
      write_enable   <= we_d;
      rd             <= rd_d;
      rd_din         <= din_d;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter. Inputs change 1ns after
// the rising edge; combinational outputs are checked mid-cycle, registered
// outputs right after the edge that loads them.
module tb_rf_write_arbiter;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            pipe_valid, mcu_valid, claim_valid;
  logic [4:0]      pipe_rd, mcu_rd, claim_rd, rs1, rs2;
  logic [XLEN-1:0] pipe_data, mcu_data;
  logic            pipe_ready, mcu_ready, rs1_busy, rs2_busy, claim_conflict;
  logic            write_enable;
  logic [4:0]      rd;
  logic [XLEN-1:0] rd_din;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(
    .XLEN        (XLEN),
    .NREG        (32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pipe_valid    (pipe_valid),
    .pipe_rd       (pipe_rd),
    .pipe_data     (pipe_data),
    .pipe_ready    (pipe_ready),
    .mcu_valid     (mcu_valid),
    .mcu_rd        (mcu_rd),
    .mcu_data      (mcu_data),
    .mcu_ready     (mcu_ready),
    .claim_valid   (claim_valid),
    .claim_rd      (claim_rd),
    .rs1           (rs1),
    .rs2           (rs2),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .claim_conflict(claim_conflict),
    .write_enable  (write_enable),
    .rd            (rd),
    .rd_din        (rd_din)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1ns past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  int unsigned exp_rd [5] = '{3, 3, 3, 3, 7};

  initial begin
    reset = 1'b0;
    pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'h1111_2222;
    mcu_valid = 1'b0; mcu_rd = '0; mcu_data = '0;
    claim_valid = 1'b0; claim_rd = '0;
    rs1 = 5'd5; rs2 = 5'd0;

    // Reset held two cycles with a pipe request present: nothing written.
    step();
    step();
    check_eq("rst_we", write_enable, 0);
    check_eq("rst_rd", rd, 0);
    check_eq("rst_din", rd_din, 0);
    check_eq("rst_busy", rs1_busy, 0);
    check_eq("rst_conflict", claim_conflict, 0);

    // Release reset; single pipe write.
    reset = 1'b1;
    pipe_data = 32'hDEAD_BEEF;
    settle();
    check_eq("pipe_ready", pipe_ready, 1);
    step();
    check_eq("pipe_we", write_enable, 1);
    check_eq("pipe_rd", rd, 5);
    check_eq("pipe_din", rd_din, 32'hDEAD_BEEF);
    pipe_valid = 1'b0;
    step();
    check_eq("idle_we", write_enable, 0);

    // Contention: pipe wins four cycles, mcu wins the fifth.
    pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 32'hAAAA_0003;
    mcu_valid = 1'b1; mcu_rd = 5'd7; mcu_data = 32'hBBBB_0007;
    for (int i = 0; i < 5; i++) begin
      settle();
      check_eq($sformatf("cont_pready%0d", i), pipe_ready, (i < 4) ? 1 : 0);
      check_eq($sformatf("cont_mready%0d", i), mcu_ready, (i == 4) ? 1 : 0);
      step();
      check_eq($sformatf("cont_we%0d", i), write_enable, 1);
      check_eq($sformatf("cont_rd%0d", i), rd, exp_rd[i]);
      check_eq($sformatf("cont_din%0d", i), rd_din,
               (i < 4) ? 32'hAAAA_0003 : 32'hBBBB_0007);
    end
    // Counter back to zero: pipe wins again.
    settle();
    check_eq("starve_clr_pready", pipe_ready, 1);
    check_eq("starve_clr_mready", mcu_ready, 0);
    pipe_valid = 1'b0; mcu_valid = 1'b0;
    step();
    check_eq("cont_idle_we", write_enable, 0);

    // Scoreboard and WAW blocking on r9.
    claim_valid = 1'b1; claim_rd = 5'd9; rs1 = 5'd9;
    settle();
    check_eq("claim_same_cycle_busy", rs1_busy, 0);
    step();
    claim_valid = 1'b0;
    check_eq("claim_busy", rs1_busy, 1);
    pipe_valid = 1'b1; pipe_rd = 5'd9; pipe_data = 32'hCAFE_0009;
    settle();
    check_eq("waw_pready", pipe_ready, 0);
    step();
    check_eq("waw_we", write_enable, 0);
    mcu_valid = 1'b1; mcu_rd = 5'd9; mcu_data = 32'hF00D_0009;
    settle();
    check_eq("waw_mready", mcu_ready, 1);
    check_eq("waw_pready2", pipe_ready, 0);
    step();
    mcu_valid = 1'b0;
    check_eq("waw_mcu_we", write_enable, 1);
    check_eq("waw_mcu_rd", rd, 9);
    check_eq("waw_mcu_din", rd_din, 32'hF00D_0009);
    check_eq("waw_busy_clr", rs1_busy, 0);
    settle();
    check_eq("waw_pready3", pipe_ready, 1);
    step();
    pipe_valid = 1'b0;
    check_eq("waw_pipe_rd", rd, 9);
    check_eq("waw_pipe_din", rd_din, 32'hCAFE_0009);

    // x0 write: accepted, no write enable.
    pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'h1234_5678;
    settle();
    check_eq("x0_pready", pipe_ready, 1);
    step();
    pipe_valid = 1'b0;
    check_eq("x0_we", write_enable, 0);
    check_eq("x0_rd", rd, 0);

    // Double claim of r12 without an mcu result -> sticky conflict.
    claim_valid = 1'b1; claim_rd = 5'd12; rs2 = 5'd12;
    step();
    check_eq("conf_first", claim_conflict, 0);
    check_eq("conf_busy", rs2_busy, 1);
    step();
    claim_valid = 1'b0;
    check_eq("conf_set", claim_conflict, 1);
    check_eq("conf_busy2", rs2_busy, 1);
    step();
    step();
    check_eq("conf_hold", claim_conflict, 1);

    // Reset clears conflict and scoreboard.
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_eq("conf_rst", claim_conflict, 0);
    check_eq("conf_rst_busy", rs2_busy, 0);

    // Same-register set and clear in one cycle: claim survives, no conflict.
    claim_valid = 1'b1; claim_rd = 5'd4; rs1 = 5'd4;
    step();
    mcu_valid = 1'b1; mcu_rd = 5'd4; mcu_data = 32'h0000_0044;
    settle();
    check_eq("sc_mready", mcu_ready, 1);
    step();
    claim_valid = 1'b0;
    check_eq("sc_busy", rs1_busy, 1);
    check_eq("sc_conflict", claim_conflict, 0);
    check_eq("sc_we", write_enable, 1);
    check_eq("sc_rd", rd, 4);
    // Second result for r4 finally clears it.
    step();
    mcu_valid = 1'b0;
    check_eq("sc_busy_clr", rs1_busy, 0);
    check_eq("sc_conflict2", claim_conflict, 0);
    step();
    check_eq("final_we", write_enable, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single synchronous write port between two writeback requesters: the in-order pipeline WB stage ("pipe") and a long-latency multi-cycle unit ("mcu").
- Tracks registers with an outstanding mcu result in a pending scoreboard.
- Drives busy flags to hazard detection and blocks WAW-unsafe pipe writes.
- Sits between the writeback sources and the register file's write_enable/rd/rd_din inputs.

Parameters:
XLEN, 32, data width of write port
NREG, 32, number of architectural registers (index width = log2(NREG))
STARVE_LIMIT, 4, consecutive mcu-blocked cycles before mcu gets priority (>=1)

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-low reset (state cleared on posedge clk while reset==0)
pipe_valid  input  1  pipe has a writeback
pipe_rd  input  5  pipe destination register
pipe_data  input  XLEN  pipe write data
pipe_ready  output  1  pipe writeback accepted this cycle (combinational)
mcu_valid  input  1  mcu has a result
mcu_rd  input  5  mcu destination register
mcu_data  input  XLEN  mcu result
mcu_ready  output  1  mcu result accepted this cycle (combinational)
claim_valid  input  1  issue of an mcu op this cycle
claim_rd  input  5  destination register of issued mcu op
rs1  input  5  hazard query register 1
rs2  input  5  hazard query register 2
rs1_busy  output  1  pending[rs1] (combinational)
rs2_busy  output  1  pending[rs2] (combinational)
claim_conflict  output  1  sticky error: claim to an already-pending register
write_enable  output  1  register file write enable (registered)
rd  output  5  register file write index (registered)
rd_din  output  XLEN  register file write data (registered)

Behaviour:
- Reset (reset==0 at posedge): pending=0, starve_cnt=0, write_enable=0, rd=0, rd_din=0, claim_conflict=0. Results accepted before reset are dropped and never written.
- Acceptance: a request is accepted when valid && ready in the same cycle. At most one is accepted per cycle.
- Registered write stage: on the posedge after acceptance, write_enable=1, rd=accepted rd, rd_din=accepted data.
- Register-file timing: accept in cycle N -> write_enable high in cycle N+1 -> register file updated at the end of cycle N+1.
- write_enable=0 in any cycle following a no-accept cycle.
- x0 handling: a request with rd==0 is accepted normally, but the next cycle's write_enable stays 0. Scoreboard bit 0 is never set.
- pipe_ready: pipe_valid && !pending[pipe_rd] && !(mcu_valid && mcu_wins).
- mcu_ready: mcu_valid && (!pipe_eligible || mcu_wins), where pipe_eligible = pipe_valid && !pending[pipe_rd].
- mcu_wins: starve_cnt==STARVE_LIMIT. Otherwise pipe has fixed priority.
- starve_cnt:
  - cleared when mcu is accepted or mcu_valid==0.
  - incremented when mcu_valid && !mcu_ready.
  - saturates at STARVE_LIMIT.
- Scoreboard set: claim_valid && claim_rd!=0 sets pending[claim_rd] at the posedge.
- Scoreboard clear: mcu acceptance clears pending[mcu_rd] at the posedge.
- Same-register set and clear in one cycle: set wins (new claim survives).
- Claim conflict: claim to a register already pending (and not being cleared that cycle) sets claim_conflict=1, held until reset. The pending bit stays set.
- WAW blocking: a pipe write to a pending register is held off (pipe_ready=0) until the mcu result is accepted. It may be accepted in the cycle after the mcu acceptance.
- Busy flags: rs1_busy/rs2_busy reflect current registered pending only. Same-cycle claims are not visible.
- No internal queueing: requesters hold valid/rd/data stable until ready.

Test Plan:
- Reset: hold reset=0 two cycles with pipe_valid=1 -> write_enable=0, rd=0, rd_din=0, busy=0, claim_conflict=0. Release reset -> pipe write appears next cycle.
- Single pipe write: pipe_valid=1, pipe_rd=5, pipe_data=32'hDEAD_BEEF -> pipe_ready=1 same cycle. Next cycle write_enable=1, rd=5, rd_din=32'hDEADBEEF. Following cycle write_enable=0.
- Contention/starvation: pipe_valid held 1 (rd=3) and mcu_valid held 1 (rd=7) with STARVE_LIMIT=4 -> pipe wins 4 cycles, mcu wins the 5th cycle. Registered rd sequence 3,3,3,3,7. starve_cnt returns to 0.
- Scoreboard/WAW: claim rd=9. Next cycle rs1=9 -> rs1_busy=1. pipe_valid rd=9 -> pipe_ready=0. mcu_valid rd=9 accepted -> pipe accepted the following cycle. rs1_busy=0 after the mcu accept edge.
- x0 and conflict: pipe write rd=0 -> accepted, write_enable stays 0. claim rd=12 twice without an mcu result -> claim_conflict=1 and stays 1 until reset.
- Simultaneous set/clear: mcu result rd=4 (pending) accepted in the same cycle as a new claim rd=4 -> pending[4] remains 1, claim_conflict stays 0.
